// File: rtl/mm_control_pkg.sv
// Shared types and register map for the multi-channel start/finish controller.
package mm_control_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StBusy  = 2'd2
    } ch_state_e;

    localparam int unsigned REG_START  = 0;
    localparam int unsigned REG_DONE   = 1;
    localparam int unsigned REG_IRQ_EN = 2;
    localparam int unsigned REG_ERR    = 3;

endpackage

// File: rtl/mm_channel_fsm.sv
// One core channel: IDLE -> PULSE -> BUSY -> IDLE handshake.
// Define WATCHDOG_EN to build the BUSY-timeout counter.
module mm_channel_fsm
    import mm_control_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic start_req,
    input  logic finish,
    output logic start_pulse,
    output logic busy,
    output logic done_set,
    output logic err_set
);

    ch_state_e state_q, state_d;

`ifdef WATCHDOG_EN
    // Compared before the increment, so a match marks the (2^W-1)-th BUSY cycle.
    localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout;

    assign timeout = (cnt_q == CntLast);
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        err_set  = 1'b0;
`ifdef WATCHDOG_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_req) state_d = StPulse;
            end
            StPulse: begin
                state_d = StBusy;
`ifdef WATCHDOG_EN
                cnt_d   = '0;
`endif
            end
            StBusy: begin
                if (finish) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end else begin
`ifdef WATCHDOG_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StIdle;
`ifdef WATCHDOG_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef WATCHDOG_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign start_pulse = (state_q == StPulse);
    assign busy        = (state_q != StIdle);

endmodule

// File: rtl/mm_control_multi.sv
// Avalon-MM control slave launching NUM_CH cores and collecting done/irq.
// Define WATCHDOG_EN for per-channel BUSY timeouts reported in the ERR register.
module mm_control_multi
    import mm_control_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WIDTH_CTRL = 8,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [WIDTH_CTRL-1:0] data_write,
    output logic [WIDTH_CTRL-1:0] data_read,
    input  logic [NUM_CH-1:0]     interrupt_finish,
    output logic [NUM_CH-1:0]     interrupt_start,
    output logic                  irq
);

    logic [NUM_CH-1:0] start_req, launch, busy, start_pulse, done_set, err_set;
    logic [NUM_CH-1:0] done_q, done_d, irq_en_q, irq_en_d, err;
    logic [NUM_CH-1:0] wdata;
    logic [WIDTH_CTRL-1:0] rd_val, data_read_q;
    logic wr_start, wr_done, wr_irq_en, irq_q;

    assign wdata     = data_write[NUM_CH-1:0];
    assign wr_start  = write && (address == ADDR_W'(REG_START));
    assign wr_done   = write && (address == ADDR_W'(REG_DONE));
    assign wr_irq_en = write && (address == ADDR_W'(REG_IRQ_EN));
    assign start_req = wr_start ? wdata : '0;
    // Only channels that actually leave IDLE get their sticky flags cleared.
    assign launch    = start_req & ~busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mm_channel_fsm #(
            .TIMEOUT_W(TIMEOUT_W)
        ) u_fsm (
            .clk        (clk),
            .clear      (reset_sink_reset),
            .start_req  (start_req[i]),
            .finish     (interrupt_finish[i]),
            .start_pulse(start_pulse[i]),
            .busy       (busy[i]),
            .done_set   (done_set[i]),
            .err_set    (err_set[i])
        );
    end

    if (NUM_CH < WIDTH_CTRL) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^data_write[WIDTH_CTRL-1:NUM_CH];
    end

    always_comb begin
        done_d = done_q;
        if (wr_done) done_d = done_d & ~wdata;
        done_d = (done_d & ~launch) | done_set;
        irq_en_d = wr_irq_en ? wdata : irq_en_q;
    end

`ifdef WATCHDOG_EN
    logic [NUM_CH-1:0] err_q, err_d;
    logic wr_err;

    assign wr_err = write && (address == ADDR_W'(REG_ERR));

    always_comb begin
        err_d = err_q;
        if (wr_err) err_d = err_d & ~wdata;
        err_d = (err_d & ~launch) | err_set;
    end

    always_ff @(posedge clk) begin
        if (reset_sink_reset) err_q <= '0;
        else                  err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = |err_set;
    assign err        = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_W'(REG_START):  rd_val[NUM_CH-1:0] = busy;
            ADDR_W'(REG_DONE):   rd_val[NUM_CH-1:0] = done_q;
            ADDR_W'(REG_IRQ_EN): rd_val[NUM_CH-1:0] = irq_en_q;
            ADDR_W'(REG_ERR):    rd_val[NUM_CH-1:0] = err;
            default:             rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            done_q      <= '0;
            irq_en_q    <= '0;
            data_read_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            data_read_q <= read ? rd_val : '0;
            irq_q       <= |((done_q | err) & irq_en_q);
        end
    end

    assign data_read       = data_read_q;
    assign interrupt_start = start_pulse;
    assign irq             = irq_q;

endmodule

// File: tb/tb_mm_control_multi.sv
// Directed self-checking bench for mm_control_multi (WATCHDOG_EN section runs only when defined).
module tb_mm_control_multi;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned WIDTH_CTRL = 8;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned TIMEOUT_W  = 4;

    logic                  clk = 1'b0;
    logic                  reset_sink_reset = 1'b1;
    logic [ADDR_W-1:0]     address = '0;
    logic                  read = 1'b0;
    logic                  write = 1'b0;
    logic [WIDTH_CTRL-1:0] data_write = '0;
    logic [WIDTH_CTRL-1:0] data_read;
    logic [NUM_CH-1:0]     interrupt_finish = '0;
    logic [NUM_CH-1:0]     interrupt_start;
    logic                  irq;

    int n_tests = 0;
    int n_fail  = 0;

    mm_control_multi #(
        .NUM_CH    (NUM_CH),
        .WIDTH_CTRL(WIDTH_CTRL),
        .ADDR_W    (ADDR_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk             (clk),
        .reset_sink_reset(reset_sink_reset),
        .address         (address),
        .read            (read),
        .write           (write),
        .data_write      (data_write),
        .data_read       (data_read),
        .interrupt_finish(interrupt_finish),
        .interrupt_start (interrupt_start),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input int addr, input int val);
        address    = ADDR_W'(addr);
        data_write = WIDTH_CTRL'(val);
        write      = 1'b1;
        step();
        write      = 1'b0;
        data_write = '0;
    endtask

    task automatic reg_read(input int addr, output logic [WIDTH_CTRL-1:0] val);
        address = ADDR_W'(addr);
        read    = 1'b1;
        step();
        read    = 1'b0;
        val     = data_read;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got 0x0 expected 0x1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [WIDTH_CTRL-1:0] v;

        // Reset state
        repeat (3) step();
        reset_sink_reset = 1'b0;
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_start", 32'(interrupt_start), 32'h0);
        check_eq("rst_rdata_idle", 32'(data_read), 32'h0);
        for (int a = 0; a < 4; a++) begin
            reg_read(a, v);
            check_eq($sformatf("rst_reg%0d", a), 32'(v), 32'h0);
        end

        // Single launch on ch0
        reg_write(2, 8'h01);
        reg_write(0, 8'h01);                       // now at T+1
        check_eq("t1_pulse", 32'(interrupt_start), 32'h1);
        address = 2'd0; read = 1'b1;
        step();                                    // T+2
        check_eq("t2_pulse_gone", 32'(interrupt_start), 32'h0);
        step();                                    // T+3: busy sampled in T+2
        check_eq("busy_t2", 32'(data_read), 32'h1);
        step();                                    // T+4
        check_eq("busy_t3", 32'(data_read), 32'h1);
        step();                                    // T+5
        check_eq("busy_t4", 32'(data_read), 32'h1);
        interrupt_finish = 4'b0001;
        step();                                    // T+6
        interrupt_finish = '0;
        read = 1'b0;
        check_eq("busy_t5", 32'(data_read), 32'h1);
        check_eq("irq_t6", 32'(irq), 32'h0);
        reg_read(1, v);                            // T+7
        check_eq("done_after", 32'(v), 32'h1);
        check_eq("irq_t7", 32'(irq), 32'h1);

        // Dual launch, re-start ignored, partial finish
        reg_write(0, 8'h05);
        check_eq("dual_pulse", 32'(interrupt_start), 32'h5);
        step();
        reg_write(0, 8'h05);
        check_eq("restart_nopulse", 32'(interrupt_start), 32'h0);
        step();
        check_eq("restart_nopulse2", 32'(interrupt_start), 32'h0);
        interrupt_finish = 4'b0100;
        step();
        interrupt_finish = '0;
        reg_read(1, v);
        check_eq("done_ch2", 32'(v), 32'h4);
        reg_read(0, v);
        check_eq("busy_ch0", 32'(v), 32'h1);
        reg_write(1, 8'h04);
        reg_read(1, v);
        check_eq("done_w1c_ch2", 32'(v), 32'h0);

        // W1C colliding with a new done on ch0: set wins
        interrupt_finish = 4'b0001;
        reg_write(1, 8'h01);
        interrupt_finish = '0;
        reg_read(1, v);
        check_eq("set_wins", 32'(v), 32'h1);
        check_eq("irq_set_wins", 32'(irq), 32'h1);
        reg_write(1, 8'h01);
        check_eq("irq_lag", 32'(irq), 32'h1);
        step();
        check_eq("irq_drop", 32'(irq), 32'h0);
        reg_read(1, v);
        check_eq("done_cleared", 32'(v), 32'h0);

        // Read and write in one cycle returns the pre-write value
        address = 2'd2; read = 1'b1; write = 1'b1; data_write = 8'h0A;
        step();
        read = 1'b0; write = 1'b0; data_write = '0;
        check_eq("rw_prewrite", 32'(data_read), 32'h1);
        reg_read(2, v);
        check_eq("rw_postwrite", 32'(v), 32'h0A);

        // Spurious finish while idle
        interrupt_finish = 4'hF;
        step();
        interrupt_finish = '0;
        reg_read(1, v);
        check_eq("spurious_finish", 32'(v), 32'h0);

        // Reset while ch1 busy
        reg_write(0, 8'h02);
        step();
        step();
        reset_sink_reset = 1'b1;
        step();
        reset_sink_reset = 1'b0;
        check_eq("rst_mid_start", 32'(interrupt_start), 32'h0);
        reg_read(0, v);
        check_eq("rst_mid_busy", 32'(v), 32'h0);
        interrupt_finish = 4'b0010;
        step();
        interrupt_finish = '0;
        reg_read(1, v);
        check_eq("late_finish_ignored", 32'(v), 32'h0);

`ifdef WATCHDOG_EN
        // Timeout after 15 BUSY cycles with TIMEOUT_W=4
        reg_write(2, 8'h02);
        reg_write(0, 8'h02);                       // T+1
        repeat (13) step();                        // T+14
        reg_read(0, v);                            // busy sampled in T+14
        check_eq("wd_still_busy", 32'(v), 32'h2);
        step();                                    // T+16 (last BUSY cycle)
        step();                                    // T+17
        reg_read(3, v);
        check_eq("wd_err", 32'(v), 32'h2);
        check_eq("wd_irq", 32'(irq), 32'h1);
        reg_read(0, v);
        check_eq("wd_idle", 32'(v), 32'h0);
        reg_read(1, v);
        check_eq("wd_no_done", 32'(v), 32'h0);
        reg_write(3, 8'h02);
        reg_read(3, v);
        check_eq("wd_err_w1c", 32'(v), 32'h0);
`else
        reg_write(3, 8'hFF);
        reg_read(3, v);
        check_eq("err_reads_zero", 32'(v), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
